// File: rtl/apb_pkg.sv
// Shared types for the APB register bridge: FSM states, error causes and the
// default read-only map of the legacy UART register bank.
package apb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp
   } apb_state_e;

   typedef enum logic [2:0] {
      CauseNone,
      CauseUnmapped,
      CauseMisalign,
      CauseRoWrite,
      CauseTimeout,
      CauseRegErr
   } err_cause_e;

   // Registers 1 and 4 of the UART map are status registers.
   localparam logic [4:0] UART_RO_MASK = 5'b10010;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational decode of an APB byte address into a register index, with the
// reason an access is rejected when it does not hit a writable/readable word.
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 12,
   parameter int unsigned          NUM_REGS  = 5,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = 'h000,
   parameter logic [NUM_REGS-1:0]  RO_MASK   = UART_RO_MASK
) (
   input  logic [ADDR_W-1:0]            paddr,
   input  logic                         pwrite,
   output logic                         hit,
   output logic [$clog2(NUM_REGS)-1:0]  idx,
   output err_cause_e                   err_cause
);

   logic [ADDR_W-1:0] word;
   logic              ro;

   always_comb begin
      word = (paddr - BASE_ADDR) >> 2;
      idx  = word[$clog2(NUM_REGS)-1:0];
      ro   = |(RO_MASK & (NUM_REGS'(1) << idx));
      // Misalignment is reported ahead of range so in-window odd addresses
      // are classified by their real fault.
      if (paddr[1:0] != 2'b00) begin
         err_cause = CauseMisalign;
      end else if ((paddr < BASE_ADDR) || (word >= ADDR_W'(NUM_REGS))) begin
         err_cause = CauseUnmapped;
      end else if (pwrite && ro) begin
         err_cause = CauseRoWrite;
      end else begin
         err_cause = CauseNone;
      end
      hit = (err_cause == CauseNone);
   end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB4 slave front end: decodes a word register window and forwards legal
// accesses to a register file over a level req/ack handshake with timeout.
module apb_reg_bridge
   import apb_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 12,
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          NUM_REGS  = 5,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = 'h000,
   parameter logic [NUM_REGS-1:0]  RO_MASK   = UART_RO_MASK,
   parameter int unsigned          TIMEOUT   = 16
) (
   input  logic                         pclk,
   input  logic                         preset_n,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W/8-1:0]          pstrb,
   input  logic [DATA_W-1:0]            pwdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [DATA_W-1:0]            prdata,
   output logic                         reg_req,
   output logic                         reg_we,
   output logic [$clog2(NUM_REGS)-1:0]  reg_idx,
   output logic [DATA_W/8-1:0]          reg_strb,
   output logic [DATA_W-1:0]            reg_wdata,
   input  logic                         reg_ack,
   input  logic                         reg_err,
   input  logic [DATA_W-1:0]            reg_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   apb_state_e                   state_q;
   logic [CntW-1:0]              cnt_q;
   logic                         dec_hit;
   logic [$clog2(NUM_REGS)-1:0]  dec_idx;
   err_cause_e                   dec_cause;

   apb_addr_decode #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .BASE_ADDR(BASE_ADDR),
      .RO_MASK  (RO_MASK)
   ) u_decode (
      .paddr    (paddr),
      .pwrite   (pwrite),
      .hit      (dec_hit),
      .idx      (dec_idx),
      .err_cause(dec_cause)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         prdata    <= '0;
         reg_req   <= 1'b0;
         reg_we    <= 1'b0;
         reg_idx   <= '0;
         reg_strb  <= '0;
         reg_wdata <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               pready  <= 1'b0;
               pslverr <= 1'b0;
               prdata  <= '0;
               if (psel && !penable) begin
                  reg_we    <= pwrite;
                  reg_idx   <= dec_idx;
                  reg_strb  <= pwrite ? pstrb : '0;
                  reg_wdata <= pwdata;
                  cnt_q     <= '0;
                  if (dec_hit) begin
                     reg_req <= 1'b1;
                     state_q <= StReq;
                  end else begin
                     pready  <= 1'b1;
                     pslverr <= (dec_cause != CauseNone);
                     state_q <= StResp;
                  end
               end
            end
            StReq: begin
               cnt_q <= cnt_q + 1'b1;
               if (!psel) begin
                  // Master abandoned the transfer: drop the request silently.
                  reg_req <= 1'b0;
                  state_q <= StIdle;
               end else if (reg_ack) begin
                  reg_req <= 1'b0;
                  pready  <= 1'b1;
                  pslverr <= reg_err;
                  prdata  <= (!reg_we && !reg_err) ? reg_rdata : '0;
                  state_q <= StResp;
               end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  reg_req <= 1'b0;
                  pready  <= 1'b1;
                  pslverr <= 1'b1;
                  state_q <= StResp;
               end
            end
            StResp: begin
               pready  <= 1'b0;
               pslverr <= 1'b0;
               prdata  <= '0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed bench for apb_reg_bridge: drives APB transfers against a scripted
// register file and compares handshake timing and responses to fixed values.
module tb_apb_reg_bridge;

   logic        pclk = 1'b0;
   logic        preset_n = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [11:0] paddr = '0;
   logic [3:0]  pstrb = '0;
   logic [31:0] pwdata = '0;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata;
   logic        reg_req;
   logic        reg_we;
   logic [2:0]  reg_idx;
   logic [3:0]  reg_strb;
   logic [31:0] reg_wdata;
   logic        reg_ack = 1'b0;
   logic        reg_err = 1'b0;
   logic [31:0] reg_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   apb_reg_bridge u_dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pstrb    (pstrb),
      .pwdata   (pwdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .prdata   (prdata),
      .reg_req  (reg_req),
      .reg_we   (reg_we),
      .reg_idx  (reg_idx),
      .reg_strb (reg_strb),
      .reg_wdata(reg_wdata),
      .reg_ack  (reg_ack),
      .reg_err  (reg_err),
      .reg_rdata(reg_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge. ack_at = cycle offset after SETUP at which reg_ack is
   // driven (0 = never). Returns pready latency, response and first-REQ fields.
   task automatic xfer(input logic wr, input logic [11:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, input int ack_at, input logic [31:0] rd,
                       input logic rerr, output int lat, output logic err,
                       output logic [31:0] data, output int reqs, output logic [2:0] idx,
                       output logic [3:0] st, output logic we, output logic [31:0] wd,
                       output logic post_rdy);
      lat = 0; err = 1'b0; data = '0; reqs = 0; idx = '0; st = '0; we = 1'b0; wd = '0;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pstrb = strb; pwdata = wdata;
      for (int k = 1; k <= 40; k++) begin
         @(negedge pclk);
         penable = 1'b1;
         if (reg_req) begin
            if (reqs == 0) begin
               idx = reg_idx; st = reg_strb; we = reg_we; wd = reg_wdata;
            end
            reqs++;
         end
         if (pready) begin
            lat = k; err = pslverr; data = prdata;
            reg_ack = 1'b0;
            break;
         end
         reg_ack = (k == ack_at);
         reg_rdata = rd;
         reg_err = rerr;
      end
      @(negedge pclk);
      post_rdy = pready;
      psel = 1'b0; penable = 1'b0; reg_ack = 1'b0;
   endtask

   int          lat, reqs;
   logic        err, we, post_rdy;
   logic [31:0] data, wd;
   logic [2:0]  idx;
   logic [3:0]  st;

   initial begin
      repeat (2) @(negedge pclk);
      check("rst_pready", 32'(pready), 0);
      check("rst_pslverr", 32'(pslverr), 0);
      check("rst_prdata", prdata, 0);
      check("rst_reg_req", 32'(reg_req), 0);
      preset_n = 1'b1;
      @(negedge pclk);

      // Write 0xA5A5_0001 to 'h008, ack one cycle after SETUP.
      xfer(1'b1, 12'h008, 4'hF, 32'hA5A5_0001, 1, 32'h0, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("wr_latency", 32'(lat), 2);
      check("wr_pslverr", 32'(err), 0);
      check("wr_reqs", 32'(reqs), 1);
      check("wr_idx", 32'(idx), 2);
      check("wr_strb", 32'(st), 32'hF);
      check("wr_we", 32'(we), 1);
      check("wr_wdata", wd, 32'hA5A5_0001);
      check("wr_pready_clear", 32'(post_rdy), 0);

      // Read 'h004, ack three cycles after SETUP, strobes ignored.
      xfer(1'b0, 12'h004, 4'hF, 32'h0, 3, 32'h55, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("rd_latency", 32'(lat), 4);
      check("rd_reqs", 32'(reqs), 3);
      check("rd_prdata", data, 32'h55);
      check("rd_pslverr", 32'(err), 0);
      check("rd_idx", 32'(idx), 1);
      check("rd_strb", 32'(st), 0);

      // Read-only write, unmapped write, misaligned read: zero wait states.
      xfer(1'b1, 12'h010, 4'hF, 32'h1, 1, 32'h0, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("ro_latency", 32'(lat), 1);
      check("ro_pslverr", 32'(err), 1);
      check("ro_reqs", 32'(reqs), 0);
      xfer(1'b1, 12'h014, 4'hF, 32'h1, 1, 32'h0, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("unmap_latency", 32'(lat), 1);
      check("unmap_pslverr", 32'(err), 1);
      check("unmap_reqs", 32'(reqs), 0);
      xfer(1'b0, 12'h006, 4'h0, 32'h0, 1, 32'h77, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("mis_latency", 32'(lat), 1);
      check("mis_pslverr", 32'(err), 1);
      check("mis_reqs", 32'(reqs), 0);
      check("mis_prdata", data, 0);

      // Write with all strobes low is legal and forwarded as-is.
      xfer(1'b1, 12'h000, 4'h0, 32'h1234, 1, 32'h0, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("strb0_pslverr", 32'(err), 0);
      check("strb0_strb", 32'(st), 0);
      check("strb0_latency", 32'(lat), 2);

      // Read 'h00C with no ack: timeout.
      xfer(1'b0, 12'h00C, 4'h0, 32'h0, 0, 32'hDEAD, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("to_latency", 32'(lat), 17);
      check("to_reqs", 32'(reqs), 16);
      check("to_pslverr", 32'(err), 1);
      check("to_prdata", data, 0);

      // Register file error on a read.
      xfer(1'b0, 12'h004, 4'h0, 32'h0, 1, 32'hFFFF, 1'b1,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("rerr_pslverr", 32'(err), 1);
      check("rerr_prdata", data, 0);

      // Reset mid-REQ drops outputs immediately.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h00C;
      @(negedge pclk);
      penable = 1'b1;
      check("prerst_reg_req", 32'(reg_req), 1);
      preset_n = 1'b0;
      #1;
      check("arst_reg_req", 32'(reg_req), 0);
      check("arst_pready", 32'(pready), 0);
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
      xfer(1'b0, 12'h000, 4'h0, 32'h0, 1, 32'h1234_5678, 1'b0,
           lat, err, data, reqs, idx, st, we, wd, post_rdy);
      check("post_rst_latency", 32'(lat), 2);
      check("post_rst_prdata", data, 32'h1234_5678);
      check("post_rst_pslverr", 32'(err), 0);
      check("post_rst_idx", 32'(idx), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
